// File: rtl/startup_pkg.sv
// Shared definitions for the power-up init sequencer: state encoding,
// output widths, parameter limits and a counter-width helper.
package startup_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_SETTLE   = 3'd0;
  localparam state_t ST_WAIT_ACK = 3'd1;
  localparam state_t ST_GAP      = 3'd2;
  localparam state_t ST_DONE     = 3'd3;
  localparam state_t ST_FAULT    = 3'd4;

  localparam int RETRY_W = 8;

  localparam int SETTLE_MIN  = 1;
  localparam int SETTLE_MAX  = 65535;
  localparam int STEPS_MIN   = 1;
  localparam int STEPS_MAX   = 16;
  localparam int TIMEOUT_MIN = 1;
  localparam int TIMEOUT_MAX = 65535;
  localparam int RETRIES_MAX = 7;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/startup_reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on clk.
module startup_reset_sync (
  input  logic clk,
  input  logic nrst,
  output logic rst_n_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= 1'b1;
      r_sync <= r_meta;
    end
  end

  assign rst_n_sync = r_sync;

endmodule

// File: rtl/startup_sequencer.sv
// Power-up init sequencer: settle, then one req/ack handshake per step with
// timeout/retry. Optional macro STARTUP_RESET_SYNC_EN adds a reset synchronizer.
module startup_sequencer
  import startup_pkg::*;
#(
  parameter  int SETTLE_CYCLES  = 16,
  parameter  int NUM_STEPS      = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  parameter  int MAX_RETRIES    = 2,
  localparam int IDX_W          = cnt_w(NUM_STEPS)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               restart,
  input  logic               step_ack,
  output logic               step_req,
  output logic [IDX_W-1:0]   step_idx,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_total
);

  localparam int SET_W = cnt_w(SETTLE_CYCLES);
  localparam int TMO_W = cnt_w(TIMEOUT_CYCLES);
  localparam int RTY_W = cnt_w(MAX_RETRIES + 1);

  logic w_rst_n;

`ifdef STARTUP_RESET_SYNC_EN
  startup_reset_sync u_rst_sync (
    .clk        (clk),
    .nrst       (nrst),
    .rst_n_sync (w_rst_n)
  );
`else
  assign w_rst_n = nrst;
`endif

  state_t             r_state;
  logic [SET_W-1:0]   r_settle_cnt;
  logic [TMO_W-1:0]   r_timer;
  logic [RTY_W-1:0]   r_retry_cnt;
  logic               r_step_req;
  logic [IDX_W-1:0]   r_step_idx;
  logic               r_ready;
  logic               r_fault;
  logic [RETRY_W-1:0] r_retry_total;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= ST_SETTLE;
      r_settle_cnt  <= '0;
      r_timer       <= '0;
      r_retry_cnt   <= '0;
      r_step_req    <= 1'b0;
      r_step_idx    <= '0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
      r_retry_total <= '0;
    end else if (restart) begin
      r_state       <= ST_SETTLE;
      r_settle_cnt  <= '0;
      r_timer       <= '0;
      r_retry_cnt   <= '0;
      r_step_req    <= 1'b0;
      r_step_idx    <= '0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
      r_retry_total <= '0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            r_state    <= ST_WAIT_ACK;
            r_step_req <= 1'b1;
            r_timer    <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          // An ack arriving on the timeout edge still completes the step.
          if (step_ack) begin
            r_step_req  <= 1'b0;
            r_retry_cnt <= '0;
            if (r_step_idx == IDX_W'(NUM_STEPS - 1)) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
            end else begin
              r_step_idx <= r_step_idx + 1'b1;
              r_state    <= ST_GAP;
            end
          end else if (r_timer == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_step_req <= 1'b0;
            if (r_retry_cnt == RTY_W'(MAX_RETRIES)) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_retry_cnt <= r_retry_cnt + 1'b1;
              if (r_retry_total != '1)
                r_retry_total <= r_retry_total + 1'b1;
              r_state <= ST_GAP;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_GAP: begin
          r_step_req <= 1'b1;
          r_timer    <= '0;
          r_state    <= ST_WAIT_ACK;
        end
        ST_DONE, ST_FAULT: begin
          r_step_req <= 1'b0;
        end
        default: begin
          r_state    <= ST_SETTLE;
          r_step_req <= 1'b0;
        end
      endcase
    end
  end

  assign step_req    = r_step_req;
  assign step_idx    = r_step_idx;
  assign ready       = r_ready;
  assign fault       = r_fault;
  assign retry_total = r_retry_total;

endmodule

// File: tb/tb_startup_sequencer.sv
// Self-checking bench: hand-computed vector table, directed restart/reset
// sequences, and randomized ack/restart/reset against a behavioural model.
module tb_startup_sequencer;

  localparam int SETTLE = 16;
  localparam int STEPS  = 4;
  localparam int TMO    = 8;
  localparam int MAXR   = 2;
`ifdef STARTUP_RESET_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       restart = 1'b0;
  logic       step_ack = 1'b0;
  logic       step_req;
  logic [1:0] step_idx;
  logic       ready;
  logic       fault;
  logic [7:0] retry_total;

  startup_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .NUM_STEPS      (STEPS),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES    (MAXR)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .restart     (restart),
    .step_ack    (step_ack),
    .step_req    (step_req),
    .step_idx    (step_idx),
    .ready       (ready),
    .fault       (fault),
    .retry_total (retry_total)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase plus elapsed/remaining cycle counts.
  localparam int PH_SETTLE = 0, PH_REQ = 1, PH_GAP = 2, PH_DONE = 3, PH_FAULT = 4;
  int m_ph, m_wait, m_age, m_step, m_att, m_retries;

  task automatic m_reset(input int w);
    m_ph = PH_SETTLE; m_wait = w; m_age = 0; m_step = 0; m_att = 0; m_retries = 0;
  endtask

  task automatic m_edge();
    if (!nrst) m_reset(SETTLE + LAT);
    else if (restart) m_reset(SETTLE);
    else begin
      case (m_ph)
        PH_SETTLE: begin
          m_wait--;
          if (m_wait == 0) begin m_ph = PH_REQ; m_age = 0; end
        end
        PH_REQ: begin
          if (step_ack) begin
            m_att = 0;
            if (m_step == STEPS - 1) m_ph = PH_DONE;
            else begin m_step++; m_ph = PH_GAP; end
          end else begin
            m_age++;
            if (m_age == TMO) begin
              if (m_att == MAXR) m_ph = PH_FAULT;
              else begin m_att++; m_retries++; m_ph = PH_GAP; end
            end
          end
        end
        PH_GAP: begin m_ph = PH_REQ; m_age = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_model(input string nm);
    logic [12:0] got, exp;
    got = {step_req, step_idx, ready, fault, retry_total};
    exp = {m_ph == PH_REQ, 2'(m_step), m_ph == PH_DONE, m_ph == PH_FAULT,
           8'((m_retries > 255) ? 255 : m_retries)};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got req=%b idx=%0d rdy=%b flt=%b rt=%0d expected req=%b idx=%0d rdy=%b flt=%b rt=%0d at %0t",
               nm, got[12], got[11:10], got[9], got[8], got[7:0],
               exp[12], exp[11:10], exp[9], exp[8], exp[7:0], $time);
    end
  endtask

  task automatic cycle(input bit rs, input bit ack);
    restart = rs; step_ack = ack;
    @(posedge clk);
    m_edge();
    #1;
    cmp_model("model");
  endtask

  // Reset pulse starting mid-cycle and spanning exactly one clock edge.
  task automatic nrst_pulse();
    #3 nrst = 1'b0;
    #1;
    chk("async_clear", {step_req, step_idx, ready, fault, retry_total}, 32'h0);
    @(posedge clk);
    m_edge();
    #3 nrst = 1'b1;
  endtask

  typedef struct {
    int n; bit ack; bit rs;
    bit req; int idx; bit rdy; bit flt; int rt;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   k;
    bit   seen;

    tbl.push_back('{SETTLE - 1 + LAT, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{2, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{TMO, 0, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{TMO, 0, 0, 0, 1, 0, 0, 2});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 2});
    tbl.push_back('{TMO - 1, 0, 0, 1, 1, 0, 0, 2});
    tbl.push_back('{1, 1, 0, 0, 2, 0, 0, 2});
    tbl.push_back('{1, 0, 0, 1, 2, 0, 0, 2});
    tbl.push_back('{1, 1, 0, 0, 3, 0, 0, 2});
    tbl.push_back('{1, 0, 0, 1, 3, 0, 0, 2});
    tbl.push_back('{1, 1, 0, 0, 3, 1, 0, 2});
    tbl.push_back('{3, 1, 0, 0, 3, 1, 0, 2});
    tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{SETTLE - 1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{TMO, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{TMO, 0, 0, 0, 0, 0, 0, 2});
    tbl.push_back('{1, 0, 0, 1, 0, 0, 0, 2});
    tbl.push_back('{TMO, 0, 0, 0, 0, 0, 1, 2});
    tbl.push_back('{5, 1, 0, 0, 0, 0, 1, 2});

    m_reset(SETTLE + LAT);
    @(posedge clk);
    #1;
    chk("reset_state", {step_req, step_idx, ready, fault, retry_total}, 32'h0);
    #3 nrst = 1'b1;

    foreach (tbl[i]) begin
      repeat (tbl[i].n) cycle(tbl[i].rs, tbl[i].ack);
      chk($sformatf("tbl%0d_req", i), 32'(step_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_idx", i), 32'(step_idx), 32'(tbl[i].idx));
      chk($sformatf("tbl%0d_rdy", i), 32'(ready),    32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_flt", i), 32'(fault),    32'(tbl[i].flt));
      chk($sformatf("tbl%0d_rt", i),  32'(retry_total), 32'(tbl[i].rt));
    end

    // Restart while waiting for ack on step 2.
    cycle(1, 0);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (m_ph == PH_REQ && m_step == 2) seen = 1;
      else cycle(0, m_ph == PH_REQ);
    end
    chk("reach_step2", 32'(seen), 32'd1);
    cycle(1, 0);
    chk("restart_req", {step_req, step_idx, ready, fault, retry_total}, 32'h0);

    // Run to DONE, then pulse nrst and time the rerun.
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (m_ph == PH_DONE) seen = 1;
      else cycle(0, m_ph == PH_REQ);
    end
    chk("reach_done", 32'(ready), 32'd1);
    nrst_pulse();
    k = 0;
    for (int c = 1; c <= 40 && k == 0; c++) begin
      cycle(0, 0);
      if (step_req === 1'b1) k = c;
    end
    chk("req_rise_edge", 32'(k), 32'(SETTLE + LAT));

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) nrst_pulse();
      else cycle($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
